rr_fu_issue_arbiter: RTL and testbench
======================================

// Module: rr_fu_issue_arbiter
// PURPOSE
//  Round-robin issue arbiter sharing one non-pipelined functional unit among N
//  reservation-station entries. Each grant picks the first requesting entry at or
//  after a rotating pointer, with wrap-around. It then holds the unit busy for
//  BUSY_CYC cycles before the next grant. Sits between RS wakeup/select and the FU.
// PARAMETERS
//  N         8   number of requesting entries (power of 2)
//  IDX_W     3   index width, = log2(N)
//  BUSY_CYC  4   FU occupancy in cycles per grant (legal 1..15); 1 = fully pipelined
//  CNT_W     16  width of grant performance counter
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      synchronous reset, active low
//  req        in   N      request per entry; bit i = entry i; held until granted
//  fu_stall   in   1      FU backpressure: blocks new grants, freezes busy countdown
//  flush      in   1      pipeline flush: abort occupancy, cancel pending grant
//  gnt        out  N      one-hot grant, registered, valid when gnt_valid
//  gnt_idx    out  IDX_W  binary index of granted entry
//  gnt_valid  out  1      one-cycle pulse per grant
//  busy       out  1      FU occupied (state BUSY)
//  rr_ptr     out  IDX_W  current highest-priority entry
//  gnt_cnt    out  CNT_W  total grants issued, wraps
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; rr_ptr, gnt, gnt_idx, gnt_valid, busy,
//   busy_cnt, gnt_cnt all 0. Reset wins over every other input, including mid-BUSY.
//  Selection: eff_req = req & ~(gnt_valid ? gnt : 0). The just-granted entry is
//   masked for the cycle its grant is visible. w = first set bit of eff_req scanning
//   rr_ptr, rr_ptr+1, ... N-1, 0, ... rr_ptr-1, i.e. index arithmetic mod N.
//  States: IDLE, BUSY.
//  IDLE, cycle t, flush=0, fu_stall=0, |eff_req=1. At edge t+1:
//   - gnt=1<<w, gnt_idx=w, gnt_valid=1, gnt_cnt+=1
//   - rr_ptr=(w+1) mod N; N-1 wraps to 0
//   - BUSY_CYC==1: stay IDLE. Else: state=BUSY, busy_cnt=BUSY_CYC-1.
//  IDLE with no eff_req, fu_stall=1 or flush=1: no grant; gnt_valid=0, gnt=0 next edge.
//  BUSY: busy=1, gnt_valid=0.
//   - fu_stall=0: busy_cnt decrements each cycle.
//   - busy_cnt==1 and fu_stall=0: state=IDLE, busy_cnt=0 at next edge.
//   - fu_stall=1: busy_cnt and state hold.
//   - Result: consecutive grants are exactly BUSY_CYC cycles apart when unstalled.
//  Flush (priority over grant and countdown): next edge state=IDLE, busy_cnt=0,
//   gnt=0, gnt_valid=0. rr_ptr and gnt_cnt are retained. A flush in the arbitration
//   cycle suppresses that grant. Arbitration resumes in the cycle after the flush.
//  gnt_idx holds its last value when gnt_valid=0; gnt is 0 when gnt_valid=0.
//  Simultaneous flush+fu_stall: flush behaviour applies.
//  Requests are level; dropping req before grant simply removes the entry from the
//   scan. No request queueing or fairness state beyond rr_ptr.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with req=8'hFF, fu_stall=0 -> all outputs 0,
//    rr_ptr=0, no gnt_valid.
//  2 BUSY_CYC=4, req=8'b1000_0001 held -> grants idx 0,7,0,7 spaced 4 cycles;
//    rr_ptr 1,0,1,0; busy high 3 cycles after each grant; gnt_cnt=4.
//  3 Wrap: rr_ptr=6, req=8'b0000_0110 -> gnt_idx=1, gnt=8'b0000_0010, rr_ptr=2.
//  4 BUSY_CYC=1 build, req=8'hFF held -> gnt_valid every cycle, idx 0,1,...,7,0.
//    No index is repeated back-to-back; busy stays 0.
//  5 Flush in BUSY with busy_cnt=2 -> next cycle busy=0, state IDLE. With req pending,
//    a grant fires one cycle later; rr_ptr unchanged by the flush.
//  6 fu_stall=1 for 3 cycles while BUSY with busy_cnt=2 -> BUSY lasts 3 extra
//    cycles. fu_stall=1 in IDLE with req=8'h10 -> no grant until fu_stall drops.
//    Grant idx 4 then follows in the next cycle.

Source files
------------

// File: rtl/rr_fu_issue_arbiter.sv
// rr_fu_issue_arbiter: round-robin grant of one non-pipelined FU among N RS entries
module rr_fu_issue_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int BUSY_CYC = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             fu_stall,
  input  logic             flush,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             busy,
  output logic [IDX_W-1:0] rr_ptr,
  output logic [CNT_W-1:0] gnt_cnt
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]       state;
  logic [3:0]       busy_cnt;
  logic [N-1:0]     eff_req;
  logic [IDX_W-1:0] w;
  logic             found;
  assign busy = state == BUSY;
  // the just-granted entry is hidden while its grant is still visible
  always_comb begin
    eff_req = req & ~(gnt_valid ? gnt : '0);
    w = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (eff_req[rr_ptr + IDX_W'(k)]) begin
        w = rr_ptr + IDX_W'(k);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy_cnt  <= '0;
      rr_ptr    <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      gnt_cnt   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      busy_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (!fu_stall && found) begin
        gnt       <= N'(1) << w;
        gnt_idx   <= w;
        gnt_valid <= 1'b1;
        gnt_cnt   <= gnt_cnt + CNT_W'(1);
        rr_ptr    <= w + IDX_W'(1);
        state     <= BUSY_CYC == 1 ? IDLE : BUSY;
        busy_cnt  <= BUSY_CYC == 1 ? 4'd0 : 4'(BUSY_CYC - 1);
      end else begin
        gnt       <= '0;
        gnt_valid <= 1'b0;
      end
    end else begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      if (!fu_stall) begin
        state    <= busy_cnt == 4'd1 ? IDLE : BUSY;
        busy_cnt <= busy_cnt - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_rr_fu_issue_arbiter.sv
// tb_rr_fu_issue_arbiter: directed checks of grant order, occupancy, flush and stall
module tb_rr_fu_issue_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, fu_stall, flush;
  logic [7:0]  req, req1;
  logic [7:0]  gnt, gnt1;
  logic [2:0]  gnt_idx, gnt_idx1, rr_ptr, rr_ptr1;
  logic        gnt_valid, gnt_valid1, busy, busy1;
  logic [15:0] gnt_cnt, gnt_cnt1;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_fu_issue_arbiter #(.N(8), .IDX_W(3), .BUSY_CYC(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .fu_stall(fu_stall), .flush(flush),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .busy(busy),
    .rr_ptr(rr_ptr), .gnt_cnt(gnt_cnt)
  );

  rr_fu_issue_arbiter #(.N(8), .IDX_W(3), .BUSY_CYC(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .fu_stall(fu_stall), .flush(flush),
    .gnt(gnt1), .gnt_idx(gnt_idx1), .gnt_valid(gnt_valid1), .busy(busy1),
    .rr_ptr(rr_ptr1), .gnt_cnt(gnt_cnt1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 8'hFF; req1 = 8'h00; fu_stall = 1'b0; flush = 1'b0;
    step();
    step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_idx", 32'(gnt_idx), 0);
    chk("rst_valid", 32'(gnt_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ptr", 32'(rr_ptr), 0);
    chk("rst_cnt", 32'(gnt_cnt), 0);
    chk("rst_valid1", 32'(gnt_valid1), 0);
    rst_n = 1'b1; req = 8'h81;
    for (int g = 0; g < 4; g++) begin
      step();
      chk("rr_valid", 32'(gnt_valid), 1);
      chk("rr_idx", 32'(gnt_idx), (g % 2) ? 7 : 0);
      chk("rr_gnt", 32'(gnt), (g % 2) ? 32'h80 : 32'h01);
      chk("rr_ptr", 32'(rr_ptr), (g % 2) ? 0 : 1);
      chk("rr_cnt", 32'(gnt_cnt), 32'(g + 1));
      chk("rr_busy0", 32'(busy), 1);
      for (int k = 1; k < 4; k++) begin
        step();
        chk("rr_gap_valid", 32'(gnt_valid), 0);
        chk("rr_gap_gnt", 32'(gnt), 0);
        chk("rr_gap_busy", 32'(busy), (k < 3) ? 1 : 0);
      end
    end
    req = 8'h20;
    step();
    chk("pre_wrap_idx", 32'(gnt_idx), 5);
    chk("pre_wrap_ptr", 32'(rr_ptr), 6);
    req = 8'h06;
    step();
    step();
    step();
    chk("hold_idx", 32'(gnt_idx), 5);
    step();
    chk("wrap_valid", 32'(gnt_valid), 1);
    chk("wrap_idx", 32'(gnt_idx), 1);
    chk("wrap_gnt", 32'(gnt), 32'h02);
    chk("wrap_ptr", 32'(rr_ptr), 2);
    chk("wrap_cnt", 32'(gnt_cnt), 6);
    req = 8'h00;
    step();
    chk("fl_pre_busy", 32'(busy), 1);
    flush = 1'b1; req = 8'h10;
    step();
    chk("fl_busy", 32'(busy), 0);
    chk("fl_valid", 32'(gnt_valid), 0);
    chk("fl_ptr", 32'(rr_ptr), 2);
    chk("fl_cnt", 32'(gnt_cnt), 6);
    flush = 1'b0;
    step();
    chk("fl_gnt_valid", 32'(gnt_valid), 1);
    chk("fl_gnt_idx", 32'(gnt_idx), 4);
    chk("fl_gnt_ptr", 32'(rr_ptr), 5);
    chk("fl_gnt_cnt", 32'(gnt_cnt), 7);
    req = 8'h00;
    step();
    fu_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("st_busy", 32'(busy), 1);
    end
    fu_stall = 1'b0;
    step();
    chk("st_busy_tail", 32'(busy), 1);
    step();
    chk("st_idle", 32'(busy), 0);
    fu_stall = 1'b1; req = 8'h10;
    step();
    chk("st_idle_valid", 32'(gnt_valid), 0);
    step();
    chk("st_idle_valid2", 32'(gnt_valid), 0);
    fu_stall = 1'b0;
    step();
    chk("st_gnt_valid", 32'(gnt_valid), 1);
    chk("st_gnt_idx", 32'(gnt_idx), 4);
    chk("st_gnt_cnt", 32'(gnt_cnt), 8);
    req = 8'h00; req1 = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("p1_valid", 32'(gnt_valid1), 1);
      chk("p1_idx", 32'(gnt_idx1), 32'(k % 8));
      chk("p1_busy", 32'(busy1), 0);
      chk("p1_ptr", 32'((k + 1) % 8), 32'(rr_ptr1));
      chk("p1_cnt", 32'(gnt_cnt1), 32'(k + 1));
    end
    req1 = 8'h01;
    step();
    chk("p1_mask_valid", 32'(gnt_valid1), 0);
    chk("p1_mask_gnt", 32'(gnt1), 0);
    step();
    chk("p1_regnt_valid", 32'(gnt_valid1), 1);
    chk("p1_regnt_gnt", 32'(gnt1), 32'h01);
    chk("p1_regnt_cnt", 32'(gnt_cnt1), 10);
    req1 = 8'h00;
    rst_n = 1'b0;
    step();
    chk("rst2_cnt", 32'(gnt_cnt1), 0);
    chk("rst2_ptr", 32'(rr_ptr), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
